mod_addsub_pipe: RTL and testbench
==================================

MOD_ADDSUB_PIPE -- requirements
Module: mod_addsub_pipe

Interface
REQ-001 SHALL have parameter W, default 16: coefficient width in bits.
REQ-002 SHALL have parameter LANES, default 4: number of independent coefficient lanes per transaction.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port q, input, W: modulus, sampled with each accepted transaction.
REQ-006 SHALL have port in_valid, input, 1: input transaction present.
REQ-007 SHALL have port in_ready, output, 1: block accepts input this cycle.
REQ-008 SHALL have port op, input, 1: operation select, 0 = add, 1 = subtract.
REQ-009 SHALL have port a, input, LANES*W: first operands; lane i is bits [i*W +: W].
REQ-010 SHALL have port b, input, LANES*W: second operands, packed the same way as a.
REQ-011 SHALL have port out_valid, output, 1: result present.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-013 SHALL have port out, output, LANES*W: per-lane results, packed the same way as a.

Function
REQ-014 SHALL accept a transaction on any cycle with in_valid && in_ready.
REQ-015 SHALL deliver a result on any cycle with out_valid && out_ready.
REQ-016 SHALL be a two-stage pipeline:
- S1 registers the raw W+1-bit sum or difference per lane, plus q, op and valid.
- S2 registers the corrected W-bit result and valid.
REQ-017 SHALL have a latency of exactly 2 cycles from acceptance to out_valid when out_ready stays high.
REQ-018 SHALL sustain a throughput of one transaction per cycle while out_ready is held high.
REQ-019 SHALL advance S2 when !s2_valid || out_ready.
REQ-020 SHALL advance S1 when !s1_valid || (S2 advances).
REQ-021 SHALL drive in_ready equal to the S1 advance condition; in_ready is combinational from out_ready.
REQ-022 SHALL hold out and out_valid stable while out_valid && !out_ready; no transaction is lost or duplicated.
REQ-023 SHALL compute add per lane as: s = a + b in W+1 bits; result = s - q if s >= q, else s.
REQ-024 SHALL compute subtract per lane as: d = a - b; result = d + q (modulo 2^W) if a < b, else d.
REQ-025 SHALL guarantee, when inputs satisfy a, b < q, that every result lies in [0, q-1].
REQ-026 SHALL treat inputs with a, b >= q as out of contract; the result is undefined, with no hang or handshake corruption.
REQ-027 SHALL produce 0 at the boundaries a + b == q (add) and a == b (subtract).
REQ-028 SHALL handle q = 2^W - 1 with a = b = q - 1 without overflow, using the W+1-bit intermediate.
REQ-029 SHALL apply each transaction's own sampled q and op; changing q between back-to-back transactions affects only later ones.
REQ-030 SHALL compute all lanes identically and independently; no cross-lane carry.

Reset
REQ-031 SHALL clear s1_valid, s2_valid and out_valid to 0 and out to 0 while reset is high, taking effect on the next rising clk.
REQ-032 SHALL discard in-flight transactions on reset asserted mid-operation; in_ready is 1 on the first cycle after reset deasserts.
REQ-033 SHALL not require a reset for datapath registers other than out.

Configuration
REQ-034 SHALL, with macro MODADD_SUB_EN defined, implement op as in REQ-008 and REQ-024.
REQ-035 SHALL, without MODADD_SUB_EN, keep the op port but ignore it (every transaction is add) and omit the subtract/correction-by-add logic.

Structure
REQ-036 SHALL place the op encodings (OP_ADD = 0, OP_SUB = 1) and the default W/LANES constants in the shared package.
REQ-037 SHALL implement the per-lane S2 correction as sub-module mod_addsub_lane, instantiated LANES times by generate loop.

Verification
REQ-038 SHALL cover add boundaries with W=12, q=3329, LANES=4:
- a = {3328, 1000, 0, 1664}, b = {1, 2329, 0, 1665}, op = 0 -> out = {0, 0, 0, 0} after 2 cycles.
REQ-039 SHALL cover subtract, with MODADD_SUB_EN and q = 3329:
- a = {0, 5, 3328, 7}, b = {1, 5, 0, 3328}, op = 1 -> out = {3328, 0, 3328, 8}.
REQ-040 SHALL cover backpressure:
- stream 8 transactions with out_ready = 0 for cycles 3-6 -> in_ready = 0 once S1 and S2 are full.
- all 8 results in order, with out stable throughout the stall.
REQ-041 SHALL cover the maximum modulus: W=16, q=65535, a = b = 65534, add -> out = 65533.
REQ-042 SHALL cover reset mid-stream: assert reset with 2 transactions in flight -> out_valid = 0 and out = 0 next cycle, no stale result after release.
REQ-043 SHALL cover per-transaction q: back-to-back transactions with q = 17 then q = 3329, a = 16, b = 1 -> out = 0 then 17.

Source files
------------

// File: rtl/mod_addsub_pipe_pkg.sv
// rtl/mod_addsub_pipe_pkg.sv - shared constants for the modular add/sub pipeline
// Optional subtract support is enabled by defining MODADD_SUB_EN.
package mod_addsub_pipe_pkg;

  // Default coefficient width and lane count
  localparam int DEFAULT_W     = 16;
  localparam int DEFAULT_LANES = 4;

  // Operation encodings carried on the op port
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/mod_addsub_lane.sv
// rtl/mod_addsub_lane.sv - per-lane modular correction of the raw S1 value
// With MODADD_SUB_EN defined the lane also folds negative differences back by +q.
module mod_addsub_lane
  import mod_addsub_pipe_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [W:0]   raw_i,
  input  logic [W-1:0] q_i,
`ifdef MODADD_SUB_EN
  input  logic         op_i,
`endif
  output logic [W-1:0] res_o
);

  // Bring the W+1-bit sum (or borrow-flagged difference) back into [0, q-1]
  always_comb begin
    res_o = raw_i[W-1:0];
`ifdef MODADD_SUB_EN
    if (op_i == OP_SUB) begin
      // Bit W of the difference is the borrow, i.e. a < b
      if (raw_i[W]) begin
        res_o = raw_i[W-1:0] + q_i;
      end
    end else if (raw_i >= {1'b0, q_i}) begin
      res_o = raw_i[W-1:0] - q_i;
    end
`else
    if (raw_i >= {1'b0, q_i}) begin
      res_o = raw_i[W-1:0] - q_i;
    end
`endif
  end

endmodule

// File: rtl/mod_addsub_pipe.sv
// rtl/mod_addsub_pipe.sv - two-stage multi-lane modular add/sub pipeline with valid/ready handshake
// Define MODADD_SUB_EN to honour op (subtract); otherwise op is ignored and every transaction adds.
module mod_addsub_pipe
  import mod_addsub_pipe_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int LANES = DEFAULT_LANES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [W-1:0]       q,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               op,
  input  logic [LANES*W-1:0] a,
  input  logic [LANES*W-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out
);

  logic               s1_valid_q;
  logic [W:0]         s1_raw_d [LANES];
  logic [W:0]         s1_raw_q [LANES];
  logic [W-1:0]       s1_mod_q;
  logic               s2_valid_q;
  logic [LANES*W-1:0] s2_out_d;
  logic [LANES*W-1:0] s2_out_q;
  logic               s1_adv;
  logic               s2_adv;

`ifdef MODADD_SUB_EN
  logic               s1_op_q;
`else
  logic               unused_op;
  assign unused_op = op;
`endif

  // A stage may load when it is empty or its contents move on this cycle
  assign s2_adv    = !s2_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out       = s2_out_q;

  // Raw W+1-bit per-lane sum or difference feeding S1
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
`ifdef MODADD_SUB_EN
      if (op == OP_SUB) begin
        s1_raw_d[i] = {1'b0, a[i*W +: W]} - {1'b0, b[i*W +: W]};
      end else begin
        s1_raw_d[i] = {1'b0, a[i*W +: W]} + {1'b0, b[i*W +: W]};
      end
`else
      s1_raw_d[i] = {1'b0, a[i*W +: W]} + {1'b0, b[i*W +: W]};
`endif
    end
  end

  // S1 valid flag; cleared by reset so in-flight work is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
    end
  end

  // S1 datapath: raw lane values plus this transaction's own q and op
  always_ff @(posedge clk) begin
    if (s1_adv) begin
      for (int i = 0; i < LANES; i++) begin
        s1_raw_q[i] <= s1_raw_d[i];
      end
      s1_mod_q <= q;
`ifdef MODADD_SUB_EN
      s1_op_q  <= op;
`endif
    end
  end

  // Per-lane correction, all lanes independent
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mod_addsub_lane #(
      .W(W)
    ) u_lane (
      .raw_i (s1_raw_q[g]),
      .q_i   (s1_mod_q),
`ifdef MODADD_SUB_EN
      .op_i  (s1_op_q),
`endif
      .res_o (s2_out_d[g*W +: W])
    );
  end

  // S2 output register; holds while the consumer stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_out_q   <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_out_q <= s2_out_d;
      end
    end
  end

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// tb/tb_mod_addsub_pipe.sv - self-checking bench for mod_addsub_pipe (model + scoreboard)
module tb_mod_addsub_pipe;

  localparam int W     = 16;
  localparam int LANES = 4;
  localparam int DW    = W * LANES;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  q;
  logic          in_valid;
  logic          in_ready;
  logic          op;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  bit            saw_not_ready;
  bit            prev_stall;
  logic [DW-1:0] prev_out;

  mod_addsub_pipe #(.W(W), .LANES(LANES)) dut (
    .clk       (clk),
    .reset     (reset),
    .q         (q),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer modular arithmetic per lane
  function automatic logic [DW-1:0] model(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                                          input logic [W-1:0] qv, input logic opv);
    logic [DW-1:0] r;
    logic          sub_sel;
    int            x, y, m, s;
    r = '0;
`ifdef MODADD_SUB_EN
    sub_sel = opv;
`else
    sub_sel = 1'b0 & opv;
`endif
    m = int'(qv);
    for (int i = 0; i < LANES; i++) begin
      x = int'(av[i*W +: W]);
      y = int'(bv[i*W +: W]);
      if (sub_sel) s = (x >= y) ? x - y : x - y + m;
      else begin
        s = x + y;
        if (s >= m) s = s - m;
      end
      r[i*W +: W] = s[W-1:0];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_vec(input logic [W-1:0] qv);
    logic [DW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*W +: W] = W'($urandom_range(int'(qv) - 1, 0));
    return v;
  endfunction

  // Single compare process: scoreboard, stall stability, acceptance tracking
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {63'b0, out_valid}, 64'd1);
        check("stall_hold", out, prev_out);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h with no transaction outstanding", out);
        end else begin
          check("scoreboard", out, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, q, op));
      if (in_valid && !in_ready) saw_not_ready = 1'b1;
      prev_stall = out_valid && !out_ready;
      prev_out   = out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                      input logic [W-1:0] qv, input logic opv);
    int n;
    n = 0;
    a = av; b = bv; q = qv; op = opv; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
    end
    tick();
  endtask

  task automatic expect_lit(input string name, input logic [DW-1:0] exp, input int lat);
    int n;
    @(negedge clk);
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, {63'b0, out_valid}, 64'd1);
    check(name, out, exp);
    if (lat > 0) check({name, "_latency"}, DW'(n), DW'(lat));
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] va, vb;
    logic [W-1:0]  vq;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; q = 16'd3329; op = 1'b0;
    saw_not_ready = 1'b0; prev_stall = 1'b0; prev_out = '0;
    repeat (3) tick();
    check("reset_out_valid", {63'b0, out_valid}, 64'd0);
    check("reset_out", out, 64'd0);
    reset = 1'b0;
    check("post_reset_in_ready", {63'b0, in_ready}, 64'd1);

    // Pin the model with hand-computed values
    check("model_add_pin", model({16'd3328, 16'd1000, 16'd0, 16'd1664},
                                 {16'd1, 16'd2329, 16'd0, 16'd1665}, 16'd3329, 1'b0), 64'd0);
    check("model_max_pin", model({4{16'd65534}}, {4{16'd65534}}, 16'd65535, 1'b0), {4{16'd65533}});

    // Add boundaries: every lane hits exactly q or 0
    send({16'd3328, 16'd1000, 16'd0, 16'd1664}, {16'd1, 16'd2329, 16'd0, 16'd1665}, 16'd3329, 1'b0);
    in_valid = 1'b0;
    expect_lit("add_boundary", 64'd0, 2);

    // Subtract (or add when subtract support is compiled out)
    send({16'd0, 16'd5, 16'd3328, 16'd7}, {16'd1, 16'd5, 16'd0, 16'd3328}, 16'd3329, 1'b1);
    in_valid = 1'b0;
`ifdef MODADD_SUB_EN
    expect_lit("sub_vector", {16'd3328, 16'd0, 16'd3328, 16'd8}, 2);
`else
    expect_lit("op_ignored_add", {16'd1, 16'd10, 16'd3328, 16'd6}, 2);
`endif

    // Maximum modulus without overflow
    send({4{16'd65534}}, {4{16'd65534}}, 16'd65535, 1'b0);
    in_valid = 1'b0;
    expect_lit("max_modulus", {4{16'd65533}}, 2);

    // Per-transaction q, back to back
    send({4{16'd16}}, {4{16'd1}}, 16'd17, 1'b0);
    send({4{16'd16}}, {4{16'd1}}, 16'd3329, 1'b0);
    in_valid = 1'b0;
    expect_lit("q17", 64'd0, 0);
    expect_lit("q3329", {4{16'd17}}, 0);

    // Backpressure: stall the consumer while streaming 8 transactions
    saw_not_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          va = rand_vec(16'd3329);
          vb = rand_vec(16'd3329);
          send(va, vb, 16'd3329, 1'($urandom_range(1, 0)));
        end
        in_valid = 1'b0;
      end
      begin
        repeat (2) tick();
        out_ready = 1'b0;
        repeat (4) tick();
        out_ready = 1'b1;
      end
    join
    repeat (6) tick();
    check("bp_in_ready_dropped", {63'b0, saw_not_ready}, 64'd1);
    check("bp_drained", DW'(exp_q.size()), 64'd0);

    // Reset with two transactions in flight
    out_ready = 1'b0;
    send({4{16'd5}}, {4{16'd3}}, 16'd3329, 1'b0);
    send({4{16'd6}}, {4{16'd3}}, 16'd3329, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("midreset_out_valid", {63'b0, out_valid}, 64'd0);
    check("midreset_out", out, 64'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    check("midreset_in_ready", {63'b0, in_ready}, 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_stale_result", {63'b0, out_valid}, 64'd0);
    end
    tick();

    // Randomized traffic with random backpressure, q and op
    for (int k = 0; k < 400; k++) begin
      vq        = W'($urandom_range(65535, 2));
      q         = vq;
      a         = rand_vec(vq);
      b         = rand_vec(vq);
      op        = 1'($urandom_range(1, 0));
      in_valid  = 1'($urandom_range(1, 0));
      out_ready = ($urandom_range(3, 0) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    check("final_drained", DW'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
